// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and frame/oversampling constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        idle,
        start,
        data,
        stop
    } state_type;

    localparam int OVERSAMPLE     = 16;
    localparam int MID_START_TICK = 7;
    localparam int DATA_BITS      = 8;

    localparam logic [3:0] LAST_TICK    = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK     = 4'(MID_START_TICK);
    localparam logic [2:0] LAST_BIT_IDX = 3'(DATA_BITS - 1);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both stages reset to 1.
// Latency: 2 clk cycles.
// Backpressure: none, free-running.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign sync_out = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, 16x oversampled; stop-bit checking enabled by UART_RX_FRAME_CHECK_EN.
// Latency: byte strobed one cycle after the mid-stop-bit sample (plus 2-cycle input sync).
// Backpressure: none; rx_done_tick is a one-cycle strobe, consumer must take data_byte.
module uart_rx
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_tick,
    input  logic       rx,
    output logic [7:0] data_byte,
    output logic       rx_done_tick,
    output logic       frame_err_tick
);

    logic rx_s;

    state_type  state_d, state_q;
    logic [3:0] tick_d, tick_q;
    logic [2:0] bit_count_d, bit_count_q;
    logic [7:0] shift_d, shift_q;
    logic [7:0] data_byte_d, data_byte_q;
    logic       rx_done_d, rx_done_q;
`ifdef UART_RX_FRAME_CHECK_EN
    logic       frame_err_d, frame_err_q;
`endif

    sync_2ff u_rx_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (rx),
        .sync_out (rx_s)
    );

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_count_d = bit_count_q;
        shift_d     = shift_q;
        data_byte_d = data_byte_q;
        rx_done_d   = 1'b0;
`ifdef UART_RX_FRAME_CHECK_EN
        frame_err_d = 1'b0;
`endif
        case (state_q)
            idle: begin
                if (!rx_s) begin
                    state_d = start;
                    tick_d  = 4'd0;
                end
            end
            start: begin
                if (sample_tick) begin
                    if (tick_q == MID_TICK) begin
                        if (!rx_s) begin
                            state_d     = data;
                            tick_d      = 4'd0;
                            bit_count_d = 3'd0;
                        end else begin
                            state_d = idle;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            data: begin
                if (sample_tick) begin
                    if (tick_q == LAST_TICK) begin
                        shift_d = {rx_s, shift_q[7:1]};
                        tick_d  = 4'd0;
                        if (bit_count_q == LAST_BIT_IDX) begin
                            state_d = stop;
                        end else begin
                            bit_count_d = bit_count_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            stop: begin
                if (sample_tick) begin
                    if (tick_q == LAST_TICK) begin
                        // Back to idle at mid stop bit so an immediate next start edge is caught.
                        state_d = idle;
`ifdef UART_RX_FRAME_CHECK_EN
                        if (rx_s) begin
                            data_byte_d = shift_q;
                            rx_done_d   = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
`else
                        data_byte_d = shift_q;
                        rx_done_d   = 1'b1;
`endif
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end
            end
            default: state_d = idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= idle;
            tick_q      <= 4'd0;
            bit_count_q <= 3'd0;
            shift_q     <= 8'h00;
            data_byte_q <= 8'h00;
            rx_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_count_q <= bit_count_d;
            shift_q     <= shift_d;
            data_byte_q <= data_byte_d;
            rx_done_q   <= rx_done_d;
        end
    end

`ifdef UART_RX_FRAME_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_err_d;
        end
    end

    assign frame_err_tick = frame_err_q;
`else
    assign frame_err_tick = 1'b0;
`endif

    assign data_byte    = data_byte_q;
    assign rx_done_tick = rx_done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: stimulus pushes expected bytes, a monitor pops on rx_done_tick.
// Inputs driven on the falling edge; outputs sampled on the falling edge.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_tick;
    logic       rx;
    logic [7:0] data_byte;
    logic       rx_done_tick;
    logic       frame_err_tick;

    int total    = 0;
    int passed   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int exp_done = 0;
    int exp_err  = 0;

    logic [7:0] exp_q[$];
    longint     done_t[$];
    logic [7:0] last_good;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk            (clk),
        .reset          (reset),
        .sample_tick    (sample_tick),
        .rx             (rx),
        .data_byte      (data_byte),
        .rx_done_tick   (rx_done_tick),
        .frame_err_tick (frame_err_tick)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
    endtask

    // Baud generator stand-in: one tick every 4 clocks.
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            sample_tick = 1'b1;
            @(negedge clk);
            sample_tick = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (rx_done_tick) begin
                done_cnt++;
                done_t.push_back($time);
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got byte 0x%0h, expected no strobe at time %0t", data_byte, $time);
                end else begin
                    chk("rx_byte", {24'd0, data_byte}, {24'd0, exp_q.pop_front()});
                end
            end
            if (frame_err_tick) err_cnt++;
            if (rx_done_tick && frame_err_tick) begin
                total++;
                $display("FAIL both_strobes: got done=1 err=1, expected at most one at time %0t", $time);
            end
        end
    end

    task automatic line_for(input logic v, input int clks);
        rx = v;
        repeat (clks) @(negedge clk);
    endtask

    task automatic expect_byte(input logic [7:0] b);
        exp_q.push_back(b);
        exp_done++;
        last_good = b;
    endtask

    // Bad stop bit is held low only past its mid sample so the tail is not mistaken for a start.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        line_for(1'b0, 64);
        for (int i = 0; i < 8; i++) line_for(b[i], 64);
        if (stop_bit) begin
            line_for(1'b1, 64);
        end else begin
            line_for(1'b0, 48);
            line_for(1'b1, 16);
        end
    endtask

    initial begin
        reset     = 1'b1;
        rx        = 1'b1;
        last_good = 8'h00;
        repeat (5) @(negedge clk);
        chk("reset_data_byte", {24'd0, data_byte}, 32'h00);
        chk("reset_rx_done", {31'd0, rx_done_tick}, 32'd0);
        chk("reset_frame_err", {31'd0, frame_err_tick}, 32'd0);
        reset = 1'b0;
        repeat (20) @(negedge clk);

        expect_byte(8'h55);
        send_frame(8'h55, 1'b1);
        expect_byte(8'hA3);
        send_frame(8'hA3, 1'b1);
        line_for(1'b1, 64);
        chk("a3_held", {24'd0, data_byte}, 32'hA3);

        line_for(1'b0, 16);
        line_for(1'b1, 128);
        chk("glitch_hold", {24'd0, data_byte}, 32'hA3);

`ifdef UART_RX_FRAME_CHECK_EN
        exp_err++;
`else
        expect_byte(8'h3C);
`endif
        send_frame(8'h3C, 1'b0);
        line_for(1'b1, 128);
        chk("bad_stop_byte", {24'd0, data_byte}, {24'd0, last_good});

        // Start bit plus three data bits, then reset mid-frame.
        line_for(1'b0, 64);
        line_for(1'b1, 64);
        line_for(1'b0, 64);
        line_for(1'b1, 64);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_reset_byte", {24'd0, data_byte}, 32'h00);
        chk("mid_reset_done", {31'd0, rx_done_tick}, 32'd0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        line_for(1'b1, 64);
        chk("post_reset_byte", {24'd0, data_byte}, 32'h00);
        expect_byte(8'h81);
        send_frame(8'h81, 1'b1);
        line_for(1'b1, 64);

        expect_byte(8'h00);
        expect_byte(8'hFF);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        line_for(1'b1, 64);
        if (done_t.size() >= 2) begin
            chk("b2b_gap", 32'(done_t[done_t.size()-1] - done_t[done_t.size()-2]), 32'd6400);
        end else begin
            total++;
            $display("FAIL b2b_gap: got %0d strobes, expected at least 2", done_t.size());
        end

        chk("final_byte", {24'd0, data_byte}, 32'hFF);
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("err_count", 32'(err_cnt), 32'(exp_err));
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers 8N1 bytes (1 start bit, 8 data bits LSB first, 1 stop bit) from the serial line using the same 16x-oversampling `sample_tick` that drives the transmitter. It sits at the host-facing serial input of the thermometer, beside `uart_tx`. It delivers each received byte on a parallel port with a one-cycle completion strobe.

## Interface
- Parameters: none. Frame format fixed at 8N1; oversampling fixed at 16.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `sample_tick`  in  1  one-cycle pulse from the baud rate generator; 16 pulses per bit period.
- `rx`  in  1  serial input; asynchronous to `clk`; idles high.
- `data_byte`  out  8  last completed byte; reset 8'h00.
- `rx_done_tick`  out  1  one-cycle strobe when `data_byte` is updated; reset 0.
- `frame_err_tick`  out  1  one-cycle strobe for a bad stop bit; reset 0; tied 0 unless the macro is defined.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- Internal state:
  - `tick`: 4 bits, counts `sample_tick`.
  - `bit_count`: 3 bits.
  - `shift`: 8 bits, the shift register.
- The counters advance only on cycles where `sample_tick` = 1.
- States: `idle`, `start`, `data`, `stop`.
- `idle`: when `rx_s` = 0, go to `start` and clear `tick`. `sample_tick` is not required for this transition.
- `start`: on `sample_tick` with `tick` = 7 (mid start bit):
  - If `rx_s` = 0: go to `data`, clear `tick` and `bit_count`.
  - If `rx_s` = 1: treat as a false start and return to `idle`.
  - Otherwise `tick` increments.
- `data`: on `sample_tick` with `tick` = 15 (mid data bit):
  - `shift` ← {`rx_s`, `shift[7:1]`}, so bits are assembled LSB first; clear `tick`.
  - If `bit_count` = 7, go to `stop`; otherwise `bit_count` increments.
- `stop`: on `sample_tick` with `tick` = 15 (mid stop bit), return to `idle` and complete the byte:
  - `rx_s` = 1: `data_byte` ← `shift`, pulse `rx_done_tick`.
  - `rx_s` = 0: behaviour set by the macro (see Configuration).
- `tick` wraps only via explicit clear. It never overflows, because 15 is the maximum compared value.
- `data_byte` holds its value until the next successful completion. The `shift` contents during reception never appear on `data_byte`.
- Reset mid-frame: all state returns to `idle` and outputs to their reset values. The partial byte is discarded. The next falling edge starts a fresh frame.

## Timing
- `rx_done_tick` and `frame_err_tick` are registered. Each asserts in the clock cycle after the stop-state `sample_tick` with `tick` = 15, and lasts exactly one cycle.
- `data_byte` changes in that same cycle and is valid whenever `rx_done_tick` = 1.
- Input latency: 2 `clk` cycles (synchronizer) plus up to 1 cycle for the `idle` detect.
- Start validation occurs 8 ticks after the edge is detected. Each data sample follows 16 ticks after the previous one.
- Back-to-back frames: `idle` is re-entered at mid stop bit, so a start edge arriving immediately after the stop bit is detected. No gap between frames is required.
- `rx_done_tick` and `frame_err_tick` are never both 1.

## Configuration
- Macro: `UART_RX_FRAME_CHECK_EN`.
- Defined, stop bit sampled 0:
  - `frame_err_tick` pulses.
  - `rx_done_tick` does not pulse.
  - `data_byte` is unchanged.
- Not defined:
  - The stop sample is ignored.
  - Every completed frame updates `data_byte` and pulses `rx_done_tick`.
  - `frame_err_tick` is constant 0.

## Structure
- Shared package `uart_pkg` holds:
  - `state_type` enum (`idle`, `start`, `data`, `stop`), shared with `uart_tx`.
  - Constants `OVERSAMPLE = 16`, `MID_START_TICK = 7`, `DATA_BITS = 8`.
- Sub-module `sync_2ff`: a 2-flop synchronizer with async active-high reset to 1. It is reusable for other asynchronous inputs.

## Test plan
- Frame 8'h55 at 16 ticks/bit, with `sample_tick` every 4 clks → `data_byte` = 8'h55 and exactly one `rx_done_tick` per frame.
- Frame 8'hA3 → `data_byte` = 8'hA3, confirming LSB-first assembly; no `frame_err_tick`.
- `rx` low for 4 ticks then high (glitch) → returns to `idle`; no strobes; `data_byte` holds its prior value.
- Frame 8'h3C with stop bit = 0:
  - Macro defined → one `frame_err_tick`, no `rx_done_tick`, `data_byte` unchanged.
  - Macro undefined → `rx_done_tick` with `data_byte` = 8'h3C.
- `reset` asserted after 3 data bits, then released, followed by frame 8'h81 → no strobes during the aborted frame; `data_byte` = 8'h00 after reset, then 8'h81 with one `rx_done_tick`.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap → two `rx_done_tick` pulses, 160 ticks apart, with values 8'h00 then 8'hFF.
